// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: status/control bit positions and sequencer states.
// No logic; imported by the buffer top and its FIFO.
package uart_tx_buffer_pkg;

  localparam int ST_EMPTY = 6;
  localparam int ST_FULL  = 7;
  localparam int ST_BUSY  = 8;
  localparam int ST_OVF   = 9;
  localparam int ST_TMO   = 10;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with a registered-pointer RAM, flush, and combinational head read.
// Latency: a push is visible at the head one cycle later; a push while full is refused unless a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus send sequencer feeding RS232_output: one senden pulse per byte, then wait for a fresh tx_done edge or watchdog.
// Latency: write into empty idle buffer -> senden 2 cycles later; writes to a full buffer are dropped and flagged as overflow.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1048575
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ctrl_we,
  input  logic [1:0]        ctrl_din,
  input  logic              uart_tx_done,
  output logic              uart_senden,
  output logic [DATA_W-1:0] uart_send,
  output logic [31:0]       status_dout,
  output logic              irq_empty
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);

  state_t              state;
  logic [DATA_W-1:0]   head;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic [5:0]          count6;
  logic                pop;
  logic                flush;
  logic                clr;
  logic                done;
  logic                tx_done_q;
  logic                overflow;
  logic                timeout;
  logic                ovf_set;
  logic [TW-1:0]       timer;

  assign pop     = (state == S_IDLE) && !empty;
  assign flush   = ctrl_we && ctrl_din[CTRL_FLUSH];
  assign clr     = ctrl_we && ctrl_din[CTRL_CLR];
  assign done    = uart_tx_done && !tx_done_q;
  // A pop on the same edge frees a slot, so only a non-popping full write is an overflow.
  assign ovf_set = wr_en && full && !pop && !flush;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .flush (flush),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= ovf_set || (overflow && !clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      uart_senden <= 1'b0;
      uart_send   <= '0;
      timer       <= '0;
      timeout     <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= uart_tx_done;
      if (clr) timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            uart_send   <= head;
            uart_senden <= 1'b1;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          uart_senden <= 1'b0;
          timer       <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (done) begin
            state <= S_IDLE;
          end else if ((TIMEOUT_CYC != 0) && (timer == TMO)) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign count6    = 6'(count);
  assign irq_empty = empty && (state == S_IDLE);

  always_comb begin
    status_dout           = '0;
    status_dout[5:0]      = count6;
    status_dout[ST_EMPTY] = empty;
    status_dout[ST_FULL]  = full;
    status_dout[ST_BUSY]  = (state != S_IDLE);
    status_dout[ST_OVF]   = overflow;
    status_dout[ST_TMO]   = timeout;
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: expected bytes are queued at stimulus time and
// popped by a monitor on every senden; directed checks cover status, latency, and edge cases.
module tb_uart_tx_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        ctrl_we = 1'b0;
  logic [1:0]  ctrl_din = 2'b00;
  logic        uart_tx_done = 1'b0;
  logic        uart_senden;
  logic [7:0]  uart_send;
  logic [31:0] status_dout;
  logic        irq_empty;

  int errors = 0;
  int checks = 0;
  int sent_cnt = 0;
  logic [7:0] exp_q [$];

  uart_tx_buffer #(
    .DEPTH_LOG2  (4),
    .DATA_W      (8),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .ctrl_we      (ctrl_we),
    .ctrl_din     (ctrl_din),
    .uart_tx_done (uart_tx_done),
    .uart_senden  (uart_senden),
    .uart_send    (uart_send),
    .status_dout  (status_dout),
    .irq_empty    (irq_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every senden pops one expected byte.
  always @(negedge clk) begin
    if (!rst && uart_senden) begin
      sent_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_senden: got byte %h expected no send", uart_send);
      end else begin
        check("send_byte", {24'h0, uart_send}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [7:0] first, input int n, input int n_expect);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
      if (i < n_expect) exp_q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_senden(input int budget);
    int n;
    n = 0;
    while (!uart_senden && n < budget) begin
      tick();
      n++;
    end
    check("senden_seen", {31'h0, uart_senden}, 32'h1);
    tick();
  endtask

  task automatic pulse_done();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
  endtask

  task automatic ctrl(input logic [1:0] v);
    ctrl_we  = 1'b1;
    ctrl_din = v;
    tick();
    ctrl_we  = 1'b0;
    ctrl_din = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_status", status_dout, 32'h0000_0040);
    check("reset_irq", {31'h0, irq_empty}, 32'h1);
    check("reset_senden", {31'h0, uart_senden}, 32'h0);
    check("reset_send", {24'h0, uart_send}, 32'h0);

    // Single byte with exact 2-cycle latency.
    wr_burst(8'h41, 1, 1);
    check("single_count1", status_dout, 32'h0000_0001);
    tick();
    check("single_senden", {31'h0, uart_senden}, 32'h1);
    check("single_send", {24'h0, uart_send}, 32'h41);
    check("single_send_status", status_dout, 32'h0000_0140);
    tick();
    check("single_senden_pulse", {31'h0, uart_senden}, 32'h0);
    pulse_done();
    check("single_idle_status", status_dout, 32'h0000_0040);
    check("single_irq", {31'h0, irq_empty}, 32'h1);

    // Burst of five.
    base = sent_cnt;
    wr_burst(8'h30, 5, 5);
    check("burst_status", status_dout, 32'h0000_0104);
    repeat (5) tick();
    check("burst_held", sent_cnt, base + 1);
    for (int i = 0; i < 4; i++) begin
      pulse_done();
      wait_senden(5);
      check("burst_count", {26'h0, status_dout[5:0]}, 32'(3 - i));
    end
    pulse_done();
    check("burst_done_status", status_dout, 32'h0000_0040);
    check("burst_sent", sent_cnt, base + 5);

    // Overflow: 18 writes, 0x61 dropped.
    wr_burst(8'h50, 18, 17);
    check("ovf_status", status_dout, 32'h0000_0390);
    ctrl(2'b01);
    check("ovf_cleared", status_dout, 32'h0000_0190);
    // Full with pop on the same edge as a write.
    pulse_done();
    wr_en   = 1'b1;
    wr_data = 8'h70;
    exp_q.push_back(8'h70);
    tick();
    wr_en = 1'b0;
    check("full_pop_push", status_dout, 32'h0000_0190);
    tick();
    for (int i = 0; i < 16; i++) begin
      pulse_done();
      wait_senden(5);
    end
    pulse_done();
    check("ovf_drained", status_dout, 32'h0000_0040);
    check("ovf_queue_empty", exp_q.size(), 32'h0);

    // Watchdog timeout.
    wr_burst(8'h22, 1, 1);
    wait_senden(5);
    n = 0;
    while (status_dout[8] && n < 300) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 32'd101);
    check("tmo_status", status_dout, 32'h0000_0440);
    // Stale high tx_done must not end the next wait.
    uart_tx_done = 1'b1;
    repeat (3) tick();
    wr_burst(8'h23, 1, 1);
    wait_senden(5);
    repeat (5) tick();
    check("stale_done_busy", {31'h0, status_dout[8]}, 32'h1);
    uart_tx_done = 1'b0;
    tick();
    pulse_done();
    check("stale_done_idle", status_dout, 32'h0000_0440);
    ctrl(2'b01);
    check("tmo_cleared", status_dout, 32'h0000_0040);

    // Flush with a coincident write: flush wins, no overflow.
    base = sent_cnt;
    wr_burst(8'h60, 6, 1);
    check("flush_pre_count", status_dout, 32'h0000_0105);
    ctrl_we  = 1'b1;
    ctrl_din = 2'b10;
    wr_en    = 1'b1;
    wr_data  = 8'h99;
    tick();
    ctrl_we  = 1'b0;
    ctrl_din = 2'b00;
    wr_en    = 1'b0;
    check("flush_status", status_dout, 32'h0000_0140);
    pulse_done();
    repeat (10) tick();
    check("flush_idle", status_dout, 32'h0000_0040);
    check("flush_sent", sent_cnt, base + 1);

    // Asynchronous reset mid-wait.
    base = sent_cnt;
    wr_burst(8'h76, 1, 1);
    wait_senden(5);
    wr_burst(8'h78, 2, 0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_status", status_dout, 32'h0000_0040);
    check("arst_senden", {31'h0, uart_senden}, 32'h0);
    check("arst_irq", {31'h0, irq_empty}, 32'h1);
    tick();
    rst = 1'b0;
    pulse_done();
    repeat (20) tick();
    check("arst_no_send", sent_cnt, base + 1);
    check("final_queue_empty", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
